exe_unit_issue_ctrl: RTL
========================

Name: exe_unit_issue_ctrl

Overview:
- Issue-side controller for the multi-cycle execution units (FDIV, FMUL, FADD_SUB, DIV, MUL, FP, FSQRT, R4). It is the initiator end of the unit start/done handshake whose result end is the EX-stage priority mux.
- Sits between ID/EX and the execution units. Issues one instruction per cycle, pulses the selected unit's start, and tracks each unit until its result is granted writeback.
- Stalls issue on a busy unit or on a RAW/WAW register hazard against in-flight results.

Parameters:
- NUM_UNITS, 10: number of unit slots, indexed by priority_t code (FDIV_unit=0 … R4_unit=9).
- SINGLE_CYCLE_MASK, 10'b00_1100_0000: bit u=1 marks a single-cycle unit (ALU_unit=6, DEFAULT_unit=7). These get no start pulse and no tracking.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- issue_valid_i  in  1  ID/EX holds an instruction to issue.
- issue_unit_i  in  4  target unit, priority_t encoding.
- issue_rd_i  in  5  destination register.
- issue_rd_fp_i  in  1  rd is in the FP file (1) or the integer file (0).
- issue_rd_we_i  in  1  instruction writes rd.
- rs1_i, rs2_i, rs3_i  in  5 each  source registers.
- rs_fp_i  in  3  per-source file select; bit0=rs1, bit1=rs2, bit2=rs3.
- rs_used_i  in  3  per-source valid, same bit order.
- done_i  in  NUM_UNITS  unit u result ready (level).
- wb_grant_i  in  NUM_UNITS  priority mux accepted unit u's result this cycle.
- flush_i  in  1  discard all in-flight tracking.
- stall_o  out  NUM_UNITS→1  hold ID/EX; issue is not accepted.
- start_o  out  NUM_UNITS  one-cycle start pulse per unit (registered).
- busy_o  out  NUM_UNITS  unit u state is not IDLE.
- protocol_err_o  out  1  sticky handshake-violation flag.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All unit FSMs go to IDLE and scoreboard entries are cleared.
  - start_o=0, busy_o=0, protocol_err_o=0.
  - stall_o is combinational and therefore 0 after reset.
  - Reset mid-operation abandons in-flight work; done_i and wb_grant_i for that work are then ignored.
- Accept: issue_valid_i && !stall_o && !flush_i.
- Unit index: codes ≥ NUM_UNITS are treated as single-cycle.
- Per-unit FSM (multi-cycle units only):
  - IDLE → START on accept targeting u. The scoreboard latches {rd, rd_fp, rd_we}.
  - START: start_o[u]=1 for exactly this cycle. done_i[u] is ignored. Next state is BUSY.
  - BUSY, done_i[u] && wb_grant_i[u]: go to IDLE.
  - BUSY, done_i[u] only: go to WAIT_WB.
  - WAIT_WB, wb_grant_i[u]: go to IDLE. Otherwise hold WAIT_WB.
  - Issue latency: accept in cycle t → start_o at t+1.
- Scoreboard hazards (entry valid when unit state ≠ IDLE and rd_we=1):
  - Integer register x0 never matches. FP register f0 does match.
  - RAW: a used source (rs_used_i bit set) matches an entry's rd with the same file select.
  - WAW: issue_rd_we_i && issue_rd_i/issue_rd_fp_i match an entry.
- stall_o = issue_valid_i && (RAW || WAW || target unit is multi-cycle and not IDLE).
  - This applies to single-cycle targets too, for RAW/WAW only.
- Freed-same-cycle rule:
  - A unit or entry leaving to IDLE in cycle t still counts as busy in cycle t. No bypass.
  - The dependent issue is accepted at t+1.
- flush_i:
  - Takes priority. All FSMs go to IDLE next cycle and start_o is forced to 0 that next cycle.
  - No accept happens in the flush cycle.
- protocol_err_o is set by either:
  - wb_grant_i[u] while u is IDLE or START.
  - any wb_grant_i or done_i bit on a single-cycle index.
- protocol_err_o clears only on reset.
- Multiple units may be in flight simultaneously, at most one instruction per unit.

Test Plan:
- Single issue:
  - Stimulus: reset; issue FMUL_unit(1), rd=f5 (fp=1, we=1) at cycle 2.
  - Response: start_o=10'b0000000010 at cycle 3 only; busy_o[1]=1 from cycle 3.
  - Then done_i[1]&wb_grant_i[1] at cycle 8 → busy_o[1]=0 at cycle 9.
- Unit-busy stall:
  - Stimulus: DIV_unit(3) in flight; issue another DIV.
  - Response: stall_o=1 until the grant cycle. Grant at cycle 10 → accepted at cycle 11, start_o[3] at cycle 12.
- RAW/WAW scoreboard:
  - Stimulus: FDIV in flight with rd=f3. Issue ALU with rs1=x3 (fp=0).
  - Response: stall_o=0.
  - Stimulus: issue FADD with rs2=f3.
  - Response: stall_o=1.
  - Stimulus: MUL with rd=x0 in flight; issue with rs1=x0.
  - Response: stall_o=0.
- done without grant:
  - Stimulus: done_i[4] at cycle 6, wb_grant_i[4] at cycle 9.
  - Response: busy_o[4]=1 through cycle 9, 0 at cycle 10; no second start pulse.
- Flush and reset mid-op:
  - Stimulus: three units busy; flush_i=1 at cycle 7.
  - Response: busy_o=0 at cycle 8; the issue_valid_i present at cycle 7 is not accepted.
  - Stimulus: reset_n=0 during a START cycle.
  - Response: start_o=0 at the next edge.
- Protocol error:
  - Stimulus: wb_grant_i[0] while FDIV is IDLE.
  - Response: protocol_err_o=1 next cycle and stays 1 until reset_n=0.

Source files
------------

// File: rtl/exe_unit_issue_ctrl_if.sv
// Issue/handshake bundle between the ID/EX side, the execution units and the
// issue controller. The master is the environment and the slave is the controller.
interface exe_unit_issue_ctrl_if #(
    parameter int NUM_UNITS = 10
) ();
    logic                 issue_valid_i;
    logic [3:0]           issue_unit_i;
    logic [4:0]           issue_rd_i;
    logic                 issue_rd_fp_i;
    logic                 issue_rd_we_i;
    logic [4:0]           rs1_i;
    logic [4:0]           rs2_i;
    logic [4:0]           rs3_i;
    logic [2:0]           rs_fp_i;
    logic [2:0]           rs_used_i;
    logic [NUM_UNITS-1:0] done_i;
    logic [NUM_UNITS-1:0] wb_grant_i;
    logic                 flush_i;
    logic                 stall_o;
    logic [NUM_UNITS-1:0] start_o;
    logic [NUM_UNITS-1:0] busy_o;
    logic                 protocol_err_o;

    modport master (
        output issue_valid_i, issue_unit_i, issue_rd_i, issue_rd_fp_i, issue_rd_we_i,
        output rs1_i, rs2_i, rs3_i, rs_fp_i, rs_used_i,
        output done_i, wb_grant_i, flush_i,
        input  stall_o, start_o, busy_o, protocol_err_o
    );

    modport slave (
        input  issue_valid_i, issue_unit_i, issue_rd_i, issue_rd_fp_i, issue_rd_we_i,
        input  rs1_i, rs2_i, rs3_i, rs_fp_i, rs_used_i,
        input  done_i, wb_grant_i, flush_i,
        output stall_o, start_o, busy_o, protocol_err_o
    );
endinterface

// File: rtl/exe_unit_issue_ctrl.sv
// Issue controller for the multi-cycle execution units: per-unit start/done FSMs,
// a destination-register scoreboard for RAW/WAW stalls, and a sticky protocol checker.
module exe_unit_issue_ctrl #(
    parameter int                   NUM_UNITS         = 10,
    parameter logic [NUM_UNITS-1:0] SINGLE_CYCLE_MASK = 10'b00_1100_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    exe_unit_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_WAIT_WB = 2'd3
    } state_t;

    state_t               state_r [NUM_UNITS];
    logic [4:0]           sb_rd_r [NUM_UNITS];
    logic [NUM_UNITS-1:0] sb_fp_r;
    logic [NUM_UNITS-1:0] sb_we_r;
    logic [NUM_UNITS-1:0] start_r;
    logic [NUM_UNITS-1:0] busy_r;
    logic                 perr_r;

    logic [NUM_UNITS-1:0] active_s;
    logic [NUM_UNITS-1:0] hit_s;
    logic                 raw_s;
    logic                 waw_s;
    logic                 unit_busy_s;
    logic                 stall_s;
    logic                 accept_s;
    logic                 perr_set_s;

    // x0 is hardwired zero and never creates a dependency; f0 is a real register.
    function automatic logic reg_match(input logic [4:0] a, input logic a_fp,
                                       input logic [4:0] b, input logic b_fp);
        return (a == b) && (a_fp == b_fp) && (a_fp || (a != 5'd0));
    endfunction

    // Hazard detection, target decode and protocol-violation detection.
    always_comb begin
        raw_s      = 1'b0;
        waw_s      = 1'b0;
        hit_s      = {NUM_UNITS{1'b0}};
        active_s   = {NUM_UNITS{1'b0}};
        perr_set_s = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            active_s[u] = (state_r[u] != ST_IDLE);
            hit_s[u]    = (bus.issue_unit_i == 4'(u)) && !SINGLE_CYCLE_MASK[u];
            raw_s = raw_s | (active_s[u] && sb_we_r[u] && (
                      (bus.rs_used_i[0] && reg_match(bus.rs1_i, bus.rs_fp_i[0], sb_rd_r[u], sb_fp_r[u])) ||
                      (bus.rs_used_i[1] && reg_match(bus.rs2_i, bus.rs_fp_i[1], sb_rd_r[u], sb_fp_r[u])) ||
                      (bus.rs_used_i[2] && reg_match(bus.rs3_i, bus.rs_fp_i[2], sb_rd_r[u], sb_fp_r[u]))));
            waw_s = waw_s | (active_s[u] && sb_we_r[u] && bus.issue_rd_we_i &&
                             reg_match(bus.issue_rd_i, bus.issue_rd_fp_i, sb_rd_r[u], sb_fp_r[u]));
            perr_set_s = perr_set_s | (SINGLE_CYCLE_MASK[u] ?
                         (bus.done_i[u] || bus.wb_grant_i[u]) :
                         (bus.wb_grant_i[u] && ((state_r[u] == ST_IDLE) || (state_r[u] == ST_START))));
        end
        // Unknown codes decode to no hit, so they behave as single-cycle targets.
        unit_busy_s = |(hit_s & active_s);
        stall_s     = bus.issue_valid_i && (raw_s || waw_s || unit_busy_s);
        accept_s    = bus.issue_valid_i && !stall_s && !bus.flush_i;
    end

    // Per-unit start/done FSMs with registered start/busy and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_r[u] <= ST_IDLE;
                sb_rd_r[u] <= 5'd0;
            end
            sb_fp_r <= {NUM_UNITS{1'b0}};
            sb_we_r <= {NUM_UNITS{1'b0}};
            start_r <= {NUM_UNITS{1'b0}};
            busy_r  <= {NUM_UNITS{1'b0}};
            perr_r  <= 1'b0;
        end else begin
            perr_r <= perr_r | perr_set_s;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (bus.flush_i || SINGLE_CYCLE_MASK[u]) begin
                    state_r[u] <= ST_IDLE;
                    start_r[u] <= 1'b0;
                    busy_r[u]  <= 1'b0;
                end else begin
                    case (state_r[u])
                        ST_IDLE: begin
                            if (accept_s && hit_s[u]) begin
                                state_r[u] <= ST_START;
                                start_r[u] <= 1'b1;
                                busy_r[u]  <= 1'b1;
                                sb_rd_r[u] <= bus.issue_rd_i;
                                sb_fp_r[u] <= bus.issue_rd_fp_i;
                                sb_we_r[u] <= bus.issue_rd_we_i;
                            end else begin
                                start_r[u] <= 1'b0;
                                busy_r[u]  <= 1'b0;
                            end
                        end
                        // done_i is deliberately not looked at while the start pulse is out.
                        ST_START: begin
                            state_r[u] <= ST_BUSY;
                            start_r[u] <= 1'b0;
                            busy_r[u]  <= 1'b1;
                        end
                        ST_BUSY: begin
                            start_r[u] <= 1'b0;
                            if (bus.done_i[u] && bus.wb_grant_i[u]) begin
                                state_r[u] <= ST_IDLE;
                                busy_r[u]  <= 1'b0;
                            end else if (bus.done_i[u]) begin
                                state_r[u] <= ST_WAIT_WB;
                                busy_r[u]  <= 1'b1;
                            end else begin
                                state_r[u] <= ST_BUSY;
                                busy_r[u]  <= 1'b1;
                            end
                        end
                        ST_WAIT_WB: begin
                            start_r[u] <= 1'b0;
                            if (bus.wb_grant_i[u]) begin
                                state_r[u] <= ST_IDLE;
                                busy_r[u]  <= 1'b0;
                            end else begin
                                state_r[u] <= ST_WAIT_WB;
                                busy_r[u]  <= 1'b1;
                            end
                        end
                        default: begin
                            state_r[u] <= ST_IDLE;
                            start_r[u] <= 1'b0;
                            busy_r[u]  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.stall_o        = stall_s;
    assign bus.start_o        = start_r;
    assign bus.busy_o         = busy_r;
    assign bus.protocol_err_o = perr_r;

endmodule
